// File: rtl/pd_rx_symbol.sv
// USB-PD receive symbol layer: 4b5b ordered-set hunt, nibble/byte assembly and error strobes.
// Define PD_RX_CRC_EN to add the CRC-32 residual check on crc_ok.
module pd_rx_symbol #(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clock,
    input  logic       nrst,
    input  logic       enable,
    input  logic       bit_rdy,
    input  logic       bit_q,
    input  logic       pkt_act,
    output logic       sop_vld,
    output logic [2:0] sop_type,
    output logic       byte_vld,
    output logic [7:0] byte_q,
    output logic       eop,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic       crc_ok
);

    localparam logic [4:0] K_SYNC1 = 5'h18;
    localparam logic [4:0] K_SYNC2 = 5'h11;
    localparam logic [4:0] K_SYNC3 = 5'h06;
    localparam logic [4:0] K_RST1  = 5'h07;
    localparam logic [4:0] K_RST2  = 5'h19;
    localparam logic [4:0] K_EOP   = 5'h0D;

    // Oldest symbol sits in bits [4:0]
    localparam logic [19:0] PAT_SOP   = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
    localparam logic [19:0] PAT_SOPP  = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
    localparam logic [19:0] PAT_SOPPP = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
    localparam logic [19:0] PAT_HARD  = {K_RST2, K_RST1, K_RST1, K_RST1};
    localparam logic [19:0] PAT_CABLE = {K_SYNC3, K_RST1, K_SYNC1, K_RST1};

    localparam int unsigned CW = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StHunt, StData, StDone} state_t;

    function automatic logic [2:0] hits(input logic [19:0] w, input logic [19:0] pat);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (w[i*5 +: 5] == pat[i*5 +: 5]) n = n + 3'd1;
        end
        return n;
    endfunction

    // Returns {valid, nibble}
    function automatic logic [4:0] decode_sym(input logic [4:0] s);
        case (s)
            5'h1E: return 5'h10;
            5'h09: return 5'h11;
            5'h14: return 5'h12;
            5'h15: return 5'h13;
            5'h0A: return 5'h14;
            5'h0B: return 5'h15;
            5'h0E: return 5'h16;
            5'h0F: return 5'h17;
            5'h12: return 5'h18;
            5'h13: return 5'h19;
            5'h16: return 5'h1A;
            5'h17: return 5'h1B;
            5'h1A: return 5'h1C;
            5'h1B: return 5'h1D;
            5'h1C: return 5'h1E;
            5'h1D: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    state_t        state;
    // The oldest bit of the 20-bit window is shifted out before it is ever looked at again,
    // so only the newest 19 bits are stored; the incoming bit completes the window.
    logic [18:0]   hist;
    logic [19:0]   window;
    logic [2:0]    bit_cnt;
    logic          nib_odd;
    logic [3:0]    low_nib;
    logic [CW-1:0] byte_cnt;
    logic [4:0]    sym;
    logic [4:0]    sym_dec;
    logic          os_hit;
    logic [2:0]    os_type;

    assign window  = {bit_q, hist};
    assign sym     = window[19:15];
    assign sym_dec = decode_sym(sym);
    assign busy    = (state != StIdle);

    always_comb begin
        os_hit  = 1'b1;
        os_type = 3'd0;
        if (hits(window, PAT_SOP) >= 3'd3) begin
            os_type = 3'd0;
        end else if (hits(window, PAT_SOPP) >= 3'd3) begin
            os_type = 3'd1;
        end else if (hits(window, PAT_SOPPP) >= 3'd3) begin
            os_type = 3'd2;
        end else if (hits(window, PAT_HARD) == 3'd4) begin
            os_type = 3'd3;
        end else if (hits(window, PAT_CABLE) == 3'd4) begin
            os_type = 3'd4;
        end else begin
            os_hit = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= StIdle;
            hist     <= '0;
            bit_cnt  <= '0;
            nib_odd  <= 1'b0;
            low_nib  <= '0;
            byte_cnt <= '0;
            sop_vld  <= 1'b0;
            sop_type <= '0;
            byte_vld <= 1'b0;
            byte_q   <= '0;
            eop      <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            sop_vld  <= 1'b0;
            byte_vld <= 1'b0;
            eop      <= 1'b0;
            err      <= 1'b0;
            if (!enable) begin
                state    <= StIdle;
                hist     <= '0;
                bit_cnt  <= '0;
                nib_odd  <= 1'b0;
                byte_cnt <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        hist     <= '0;
                        bit_cnt  <= '0;
                        nib_odd  <= 1'b0;
                        byte_cnt <= '0;
                        if (pkt_act) state <= StHunt;
                    end
                    StHunt: begin
                        if (bit_rdy) hist <= window[19:1];
                        // A bit arriving with pkt_act falling is still checked for a match
                        if (bit_rdy && os_hit) begin
                            sop_vld  <= 1'b1;
                            sop_type <= os_type;
                            if (os_type <= 3'd2) begin
                                state    <= StData;
                                bit_cnt  <= '0;
                                nib_odd  <= 1'b0;
                                byte_cnt <= '0;
                            end else begin
                                state <= StDone;
                            end
                        end else if (!pkt_act) begin
                            state <= StIdle;
                        end
                    end
                    StData: begin
                        if (bit_rdy) begin
                            hist <= window[19:1];
                            if (bit_cnt != 3'd4) begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (sym == K_EOP) begin
                                    if (nib_odd) begin
                                        err      <= 1'b1;
                                        err_code <= 2'd3;
                                    end else begin
                                        eop <= 1'b1;
                                    end
                                    state <= StDone;
                                end else if (!sym_dec[4]) begin
                                    err      <= 1'b1;
                                    err_code <= 2'd1;
                                    state    <= StDone;
                                end else if (!nib_odd) begin
                                    low_nib <= sym_dec[3:0];
                                    nib_odd <= 1'b1;
                                end else if (byte_cnt == CW'(MAX_BYTES)) begin
                                    err      <= 1'b1;
                                    err_code <= 2'd3;
                                    state    <= StDone;
                                end else begin
                                    byte_vld <= 1'b1;
                                    byte_q   <= {sym_dec[3:0], low_nib};
                                    byte_cnt <= byte_cnt + CW'(1);
                                    nib_odd  <= 1'b0;
                                end
                            end
                        end else if (!pkt_act) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            state    <= StIdle;
                        end
                    end
                    StDone: begin
                        if (!pkt_act) state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef PD_RX_CRC_EN
    logic [31:0] crc;
    logic [31:0] crc_rev;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Trails the byte strobe by one cycle; EOP is always at least a symbol later
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            crc <= '0;
        end else if (sop_vld) begin
            crc <= 32'hFFFFFFFF;
        end else if (byte_vld) begin
            crc <= crc_byte(crc, byte_q);
        end
    end

    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++) crc_rev[i] = crc[31-i];
    end

    assign crc_ok = eop && (crc_rev == 32'hC704DD7B);
`else
    assign crc_ok = 1'b0;
`endif

endmodule

// File: doc/pd_rx_symbol.md
PD_RX_SYMBOL -- requirements
Module: pd_rx_symbol

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64, meaning the maximum number of data bytes (including CRC bytes) accepted per packet.
REQ-002 SHALL have ports: clock  in  1  system clock, the only clock; all logic on its rising edge.
REQ-003 SHALL have port: nrst  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: enable in 1 block enable; bit_rdy in 1 one-cycle decoded-bit strobe from the BMC decoder; bit_q in 1 decoded bit, valid when bit_rdy=1; pkt_act in 1 BMC decoder packet-active flag.
REQ-005 SHALL have outputs: sop_vld out 1 ordered-set strobe; sop_type out 3 (0=SOP, 1=SOP', 2=SOP'', 3=HARD_RST, 4=CABLE_RST); byte_vld out 1 byte strobe; byte_q out 8 data byte; eop out 1 end-of-packet strobe; err out 1 error strobe; err_code out 2 (1=bad symbol, 2=truncated, 3=overflow/odd nibble); busy out 1 high outside IDLE; crc_ok out 1.

Function
REQ-006 SHALL shift bit_q into a 20-bit window on each bit_rdy; the first bit on the wire is bit0 of each 5-bit symbol.
REQ-007 SHALL use K-codes: Sync-1=0x18, Sync-2=0x11, Sync-3=0x06, RST-1=0x07, RST-2=0x19, EOP=0x0D.
REQ-008 SHALL decode data nibbles 0..F from 0x1E,0x09,0x14,0x15,0x0A,0x0B,0x0E,0x0F,0x12,0x13,0x16,0x17,0x1A,0x1B,0x1C,0x1D; every other 5-bit code is invalid.
REQ-009 SHALL implement states IDLE, HUNT, DATA and DONE.
REQ-010 IDLE->HUNT when pkt_act=1.
REQ-011 HUNT: after every bit, compare the 4 window symbols (oldest first) against SOP=S1 S1 S1 S2, SOP'=S1 S1 S3 S3, SOP''=S1 S3 S1 S3, HARD_RST=R1 R1 R1 R2, CABLE_RST=R1 S1 R1 S3.
REQ-012 SOP types SHALL match when at least 3 of 4 symbols are equal; reset types SHALL require exact match; priority SHALL be the order of REQ-011.
REQ-013 On match: sop_vld=1 with sop_type for exactly one cycle, one cycle after the completing bit_rdy. SOP types -> DATA with symbol counter cleared; reset types -> DONE.
REQ-014 DATA: every 5th bit completes a symbol. The first nibble is byte_q[3:0], the second is byte_q[7:4]. byte_vld SHALL pulse one cycle after the 10th bit of each byte.
REQ-015 DATA, EOP symbol at an even nibble position: eop=1 for one cycle, then -> DONE. At an odd position: err with err_code=3 instead of eop, then -> DONE.
REQ-016 DATA, invalid symbol: err with err_code=1, no byte_vld, then -> DONE.
REQ-017 DATA, a (MAX_BYTES+1)th byte: err with err_code=3, byte suppressed, then -> DONE.
REQ-018 pkt_act=0 in HUNT: -> IDLE silently. pkt_act=0 in DATA: err with err_code=2, then -> IDLE.
REQ-019 DONE: ignore bit_rdy; -> IDLE when pkt_act=0.
REQ-020 Strobes SHALL be mutually exclusive per cycle; err_code holds its value until the next err; byte_q holds until the next byte_vld.
REQ-021 bit_rdy coincident with pkt_act falling SHALL process the bit first; the truncation check applies from the following cycle.
REQ-022 enable=0 SHALL synchronously force IDLE, clear the window and counters, drive all strobes 0, and ignore bit_rdy.

Reset
REQ-023 nrst=0 SHALL asynchronously force IDLE and clear window, counters and CRC; all outputs 0, including err_code, byte_q, sop_type and crc_ok.
REQ-024 Deassertion of nrst SHALL take effect on the next clock edge; a packet in progress is discarded without err.

Configuration
REQ-025 Macro PD_RX_CRC_EN defined: SHALL run CRC-32 (reflected 0x04C11DB7, init 0xFFFFFFFF) over every emitted byte, reinitialised at sop_vld. crc_ok=1 in the eop cycle iff the residual equals 0xC704DD7B, and 0 otherwise.
REQ-026 PD_RX_CRC_EN undefined: the crc_ok port SHALL remain and be tied 0; no CRC logic is present.

Verification
REQ-027 Preamble of 64 alternating bits, then S1 S1 S1 S2, bytes 0xA5 0x3C, EOP -> sop_vld with type 0; byte_vld twice (0xA5, 0x3C); eop once; err never.
REQ-028 Ordered set S1 S1 S3 S2 (3-of-4 against SOP) -> sop_type 0; S1 S3 S1 S3 -> sop_type 2; R1 R1 R1 R2 -> sop_type 3, no byte_vld, DONE until pkt_act=0.
REQ-029 Symbol 0x00 after 1 byte -> err_code 1 one cycle after the 5th bit of the symbol; no further byte_vld; IDLE after pkt_act=0.
REQ-030 pkt_act dropped mid-byte -> err_code 2 and busy=0 within 2 cycles; nrst pulsed mid-DATA -> all outputs 0 immediately, no err.
REQ-031 MAX_BYTES=4, 5 bytes sent -> 4 byte_vld then err_code 3; EOP after 3 nibbles -> err_code 3, no eop.
REQ-032 With PD_RX_CRC_EN: 2 payload bytes plus the correct 4-byte CRC -> crc_ok=1 in the eop cycle; one flipped payload bit -> crc_ok=0.
